// File: rtl/alu_md_control.sv
// ALU control decode plus a radix-2 multi-cycle MULT/DIV sequencer with HI/LO.
// Stalls the single-cycle core while an iterative operation is in flight.
module alu_md_control #(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [3:0]       ALUCtrl,
    output logic             stall_o,
    output logic             hilo_sel_o,
    output logic [WIDTH-1:0] hilo_rd_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   ph_q, pl_q, b_q;
    logic               div_q, neg_q, rneg_q;

    logic               rtype, is_md, is_div, is_uns, issue, div0;
    logic               mthi, mtlo, last;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_s, sub_s;
    logic [WIDTH-1:0]   nxt_hi, nxt_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        ALUCtrl = 4'b0010;
        if (ALUOp == 2'b01) begin
            ALUCtrl = 4'b0110;
        end else if (ALUOp == 2'b10) begin
            case (funct)
                6'b100010, 6'b100011: ALUCtrl = 4'b0110;
                6'b100100:            ALUCtrl = 4'b0000;
                6'b100101:            ALUCtrl = 4'b0001;
                6'b100110:            ALUCtrl = 4'b0011;
                6'b100111:            ALUCtrl = 4'b1100;
                6'b101010:            ALUCtrl = 4'b0111;
                6'b101011:            ALUCtrl = 4'b1111;
                6'b000000:            ALUCtrl = 4'b0100;
                6'b000010:            ALUCtrl = 4'b0101;
                6'b000011:            ALUCtrl = 4'b1101;
                default:              ALUCtrl = 4'b0010;
            endcase
        end
    end

    assign rtype  = valid_i && (ALUOp == 2'b10);
    assign is_md  = MD_EN && rtype && (funct[5:2] == 4'b0110);
    assign is_div = funct[1];
    assign is_uns = funct[0];
    assign issue  = is_md && (state_q == IDLE);
    assign div0   = is_div && (rt_data == '0);
    assign mthi   = MD_EN && rtype && (funct == 6'b010001) && (state_q == IDLE);
    assign mtlo   = MD_EN && rtype && (funct == 6'b010011) && (state_q == IDLE);
    assign last   = (count_q == CW'(WIDTH - 1));

    assign hilo_sel_o = MD_EN && rtype &&
                        ((funct == 6'b010000) || (funct == 6'b010010));

    assign a_neg = !is_uns && rs_data[WIDTH-1];
    assign b_neg = !is_uns && rt_data[WIDTH-1];
    assign a_mag = a_neg ? -rs_data : rs_data;
    assign b_mag = b_neg ? -rt_data : rt_data;

    // ph:pl is the product accumulator (mult) or remainder:quotient (div)
    always_comb begin
        add_s = {1'b0, ph_q} + (pl_q[0] ? {1'b0, b_q} : '0);
        sub_s = {ph_q, pl_q[WIDTH-1]} - {1'b0, b_q};
        if (!div_q) begin
            nxt_hi = add_s[WIDTH:1];
            nxt_lo = {add_s[0], pl_q[WIDTH-1:1]};
        end else if (!sub_s[WIDTH]) begin
            nxt_hi = sub_s[WIDTH-1:0];
            nxt_lo = {pl_q[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = {ph_q[WIDTH-2:0], pl_q[WIDTH-1]};
            nxt_lo = {pl_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod   = {nxt_hi, nxt_lo};
        fix_hi = nxt_hi;
        fix_lo = nxt_lo;
        if (!div_q) begin
            if (neg_q) prod = -prod;
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else begin
            if (neg_q)  fix_lo = -nxt_lo;
            if (rneg_q) fix_hi = -nxt_hi;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    stall_o = 1'b1;
                    state_d = div0 ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                count_q <= '0;
                ph_q    <= '0;
                pl_q    <= is_div ? a_mag : b_mag;
                b_q     <= is_div ? b_mag : a_mag;
                div_q   <= is_div;
                neg_q   <= a_neg ^ b_neg;
                rneg_q  <= a_neg;
                if (div0) begin
                    hi_q <= rs_data;
                    lo_q <= '1;
                end
            end else if (state_q == BUSY) begin
                ph_q    <= nxt_hi;
                pl_q    <= nxt_lo;
                count_q <= count_q + CW'(1);
                if (last) begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
            end else begin
                if (mthi) hi_q <= rs_data;
                if (mtlo) lo_q <= rs_data;
            end
        end
    end

    assign hi_o      = MD_EN ? hi_q : '0;
    assign lo_o      = MD_EN ? lo_q : '0;
    assign hilo_rd_o = funct[1] ? lo_o : hi_o;

endmodule

// File: tb/tb_alu_md_control.sv
// Randomized bench for alu_md_control against an arithmetic reference model.
// Covers the decode table, mult/div results and latency, HI/LO moves and reset.
module tb_alu_md_control;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    logic [1:0]   ALUOp;
    logic [5:0]   funct;
    logic [W-1:0] rs_data, rt_data;
    logic [3:0]   ALUCtrl;
    logic         stall_o, hilo_sel_o;
    logic [W-1:0] hilo_rd_o, hi_o, lo_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    alu_md_control #(.WIDTH(W), .MD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ALUOp(ALUOp),
        .funct(funct), .rs_data(rs_data), .rt_data(rt_data),
        .ALUCtrl(ALUCtrl), .stall_o(stall_o), .hilo_sel_o(hilo_sel_o),
        .hilo_rd_o(hilo_rd_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] dec_model(input logic [1:0] op,
                                             input logic [5:0] f);
        if (op == 2'b01) return 4'b0110;
        if (op != 2'b10) return 4'b0010;
        case (f)
            6'b100000, 6'b100001: return 4'b0010;
            6'b100010, 6'b100011: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100110: return 4'b0011;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            6'b101011: return 4'b1111;
            6'b000000: return 4'b0100;
            6'b000010: return 4'b0101;
            6'b000011: return 4'b1101;
            default:   return 4'b0010;
        endcase
    endfunction

    // returns {hi, lo}
    function automatic logic [63:0] md_model(input logic [5:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'b011000: begin p = 64'(sa * sb); return p; end
            6'b011001: return {32'h0, a} * {32'h0, b};
            6'b011010: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_md(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [63:0] r;
        int n;
        int exp_n;
        r = md_model(f, a, b);
        exp_n = (f[1] && b == 0) ? 1 : W + 1;
        valid_i = 1'b1;
        ALUOp   = 2'b10;
        funct   = f;
        rs_data = a;
        rt_data = b;
        #1;
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            tick();
        end
        check({tag, " stalls"}, 64'(n), 64'(exp_n));
        check({tag, " hi"}, 64'(hi_o), 64'(r[63:32]));
        check({tag, " lo"}, 64'(lo_o), 64'(r[31:0]));
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        tick();
        valid_i = 1'b0;
        #1;
        check({tag, " idle stall"}, 64'(stall_o), 64'(0));
        tick();
        check({tag, " hold lo"}, 64'(lo_o), 64'(exp_lo));
    endtask

    initial begin
        logic [5:0] flist [12];
        logic [5:0] mdf [4];
        flist = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                  6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                  6'b000000, 6'b000010};
        mdf = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};

        rst = 1'b1;
        valid_i = 1'b0;
        ALUOp = 2'b00;
        funct = '0;
        rs_data = '0;
        rt_data = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset stall", 64'(stall_o), 64'(0));
        check("reset hi", 64'(hi_o), 64'(0));
        check("reset lo", 64'(lo_o), 64'(0));

        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 12; i++) begin
                ALUOp = 2'(op);
                funct = flist[i];
                #1;
                check("decode", 64'(ALUCtrl), 64'(dec_model(ALUOp, funct)));
            end
            ALUOp = 2'(op);
            funct = 6'b000011;
            #1;
            check("decode sra", 64'(ALUCtrl), 64'(dec_model(ALUOp, funct)));
            for (int i = 0; i < 6; i++) begin
                funct = 6'($urandom);
                #1;
                check("decode rnd", 64'(ALUCtrl), 64'(dec_model(ALUOp, funct)));
            end
        end
        tick();

        run_md(6'b011000, 32'd7, 32'hFFFFFFFD, "mult 7*-3");
        run_md(6'b011011, 32'd100, 32'd7, "divu 100/7");
        run_md(6'b011010, 32'hFFFFFFF9, 32'd2, "div -7/2");
        run_md(6'b011010, 32'h80000000, 32'hFFFFFFFF, "div min/-1");
        run_md(6'b011010, 32'd5, 32'd0, "div 5/0");
        run_md(6'b011011, 32'hDEADBEEF, 32'd0, "divu x/0");
        run_md(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max");

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            if ($urandom_range(0, 7) == 0) b = '0;
            run_md(mdf[$urandom_range(0, 3)], a, b, "rnd");
        end

        valid_i = 1'b1;
        ALUOp = 2'b10;
        funct = 6'b010001;
        rs_data = 32'h12345678;
        #1;
        check("mthi stall", 64'(stall_o), 64'(0));
        tick();
        funct = 6'b010011;
        rs_data = 32'h9ABCDEF0;
        tick();
        funct = 6'b010000;
        #1;
        check("mfhi sel", 64'(hilo_sel_o), 64'(1));
        check("mfhi data", 64'(hilo_rd_o), 64'h12345678);
        check("mfhi stall", 64'(stall_o), 64'(0));
        funct = 6'b010010;
        #1;
        check("mflo sel", 64'(hilo_sel_o), 64'(1));
        check("mflo data", 64'(hilo_rd_o), 64'h9ABCDEF0);
        funct = 6'b100000;
        #1;
        check("add sel", 64'(hilo_sel_o), 64'(0));
        valid_i = 1'b0;
        funct = 6'b010000;
        #1;
        check("mf novalid sel", 64'(hilo_sel_o), 64'(0));
        tick();

        valid_i = 1'b1;
        ALUOp = 2'b10;
        funct = 6'b011001;
        rs_data = 32'h0001_0000;
        rt_data = 32'h0003_0000;
        for (int i = 0; i < 11; i++) tick();
        check("mid stall", 64'(stall_o), 64'(1));
        rst = 1'b1;
        valid_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rst stall", 64'(stall_o), 64'(0));
        check("rst hi", 64'(hi_o), 64'(0));
        check("rst lo", 64'(lo_o), 64'(0));
        tick();
        run_md(6'b011001, 32'd3, 32'd4, "multu 3*4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
